// File: rtl/sm83_adr_sched.sv
// rtl/sm83_adr_sched.sv - control sequencer and CPU/burst arbiter for the SM83 address latch
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   cpu_req, cpu_op, cpu_gnt    CPU microcode op request, op code, registered grant
//   burst_req/base/len/lo_only  burst request and its parameters (sampled on accept)
//   burst_busy/valid/done       burst ownership, address-valid, end-of-burst pulse
//   burst_step                  consumer advance, honoured only while burst_valid
//   burst_adr, ain_sel          burst load value and latch bus-source select
//   ctl_al_hi_we .. ctl_inc_oe  registered incrementer controls
module sm83_adr_sched #(
    parameter int ADR_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int BURST_PRIO = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [2:0]           cpu_op,
    output logic                 cpu_gnt,
    input  logic                 burst_req,
    input  logic [ADR_WIDTH-1:0] burst_base,
    input  logic [LEN_WIDTH-1:0] burst_len,
    input  logic                 burst_lo_only,
    output logic                 burst_busy,
    output logic                 burst_valid,
    input  logic                 burst_step,
    output logic                 burst_done,
    output logic [ADR_WIDTH-1:0] burst_adr,
    output logic                 ain_sel,
    output logic                 ctl_al_hi_we,
    output logic                 ctl_al_lo_we,
    output logic                 ctl_inc_dec,
    output logic                 ctl_inc_cy,
    output logic                 ctl_inc_oe
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CPU    = 3'd1,
        B_LOAD = 3'd2,
        B_HOLD = 3'd3,
        B_INC  = 3'd4,
        B_END  = 3'd5
    } state_t;

    // Control bundle order: {hi_we, lo_we, dec, cy, oe}
    localparam logic [4:0] CTL_LOAD   = 5'b11000;
    localparam logic [4:0] CTL_INC    = 5'b11011;
    localparam logic [4:0] CTL_INC_LO = 5'b01011;
    localparam bit         BPRIO      = (BURST_PRIO != 0);

    state_t               state;
    logic [4:0]           ctl;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 lo_only_q;

    function automatic logic [4:0] op_ctl(input logic [2:0] op);
        case (op)
            3'd1:    op_ctl = 5'b11000;  // LOAD
            3'd2:    op_ctl = 5'b01000;  // LOAD_LO
            3'd3:    op_ctl = 5'b10000;  // LOAD_HI
            3'd4:    op_ctl = 5'b11011;  // INC
            3'd5:    op_ctl = 5'b11111;  // DEC
            3'd6:    op_ctl = 5'b01011;  // INC_LO
            3'd7:    op_ctl = 5'b01111;  // DEC_LO
            default: op_ctl = 5'b00000;  // HOLD
        endcase
    endfunction

    assign ctl_al_hi_we = ctl[4];
    assign ctl_al_lo_we = ctl[3];
    assign ctl_inc_dec  = ctl[2];
    assign ctl_inc_cy   = ctl[1];
    assign ctl_inc_oe   = ctl[0];

    // Every output is registered to match the state being entered, so the
    // controls are settled a half cycle before the latch captures on negedge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ctl         <= '0;
            cpu_gnt     <= 1'b0;
            burst_busy  <= 1'b0;
            burst_valid <= 1'b0;
            burst_done  <= 1'b0;
            burst_adr   <= '0;
            ain_sel     <= 1'b0;
            remaining   <= '0;
            lo_only_q   <= 1'b0;
        end else begin
            ctl         <= '0;
            cpu_gnt     <= 1'b0;
            burst_valid <= 1'b0;
            burst_done  <= 1'b0;
            ain_sel     <= 1'b0;
            case (state)
                IDLE, CPU: begin
                    if (burst_req && (BPRIO || !cpu_req)) begin
                        burst_adr  <= burst_base;
                        remaining  <= burst_len;
                        lo_only_q  <= burst_lo_only;
                        burst_busy <= 1'b1;
                        if (burst_len == '0) begin
                            state      <= B_END;
                            burst_done <= 1'b1;
                        end else begin
                            state   <= B_LOAD;
                            ain_sel <= 1'b1;
                            ctl     <= CTL_LOAD;
                        end
                    end else if (cpu_req) begin
                        ctl     <= op_ctl(cpu_op);
                        cpu_gnt <= 1'b1;
                        state   <= CPU;
                    end else begin
                        state <= IDLE;
                    end
                end
                B_LOAD: begin
                    burst_valid <= 1'b1;
                    state       <= B_HOLD;
                end
                B_HOLD: begin
                    if (burst_step) begin
                        if (remaining == LEN_WIDTH'(1)) begin
                            state      <= B_END;
                            burst_done <= 1'b1;
                        end else begin
                            remaining <= remaining - LEN_WIDTH'(1);
                            state     <= B_INC;
                            ctl       <= lo_only_q ? CTL_INC_LO : CTL_INC;
                        end
                    end else begin
                        burst_valid <= 1'b1;
                    end
                end
                B_INC: begin
                    burst_valid <= 1'b1;
                    state       <= B_HOLD;
                end
                B_END: begin
                    // busy covers the done cycle and drops on the way back to IDLE
                    burst_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    burst_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_adr_sched.sv
// tb/tb_sm83_adr_sched.sv - directed self-checking bench for sm83_adr_sched
module tb_sm83_adr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [2:0]  cpu_op;
    logic        burst_req;
    logic [15:0] burst_base;
    logic [7:0]  burst_len;
    logic        burst_lo_only;
    logic        burst_step;
    logic [15:0] cpu_bus;

    logic        cpu_gnt, burst_busy, burst_valid, burst_done, ain_sel;
    logic [15:0] burst_adr;
    logic        hi_we, lo_we, inc_dec, inc_cy, inc_oe;

    logic        c_gnt, c_busy, c_valid, c_done, c_sel;
    logic [15:0] c_adr;
    logic        c_hi, c_lo, c_dec, c_cy, c_oe;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] aout = 16'h0000;
    logic [15:0] va [4];
    int          nv, done_k, ndone;
    logic        any_we;

    wire  [4:0]  ctl = {hi_we, lo_we, inc_dec, inc_cy, inc_oe};

    always #5 clk = ~clk;

    sm83_adr_sched #(.ADR_WIDTH(16), .LEN_WIDTH(8), .BURST_PRIO(1)) u_dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_gnt(cpu_gnt),
        .burst_req(burst_req), .burst_base(burst_base), .burst_len(burst_len),
        .burst_lo_only(burst_lo_only), .burst_busy(burst_busy), .burst_valid(burst_valid),
        .burst_step(burst_step), .burst_done(burst_done), .burst_adr(burst_adr),
        .ain_sel(ain_sel), .ctl_al_hi_we(hi_we), .ctl_al_lo_we(lo_we),
        .ctl_inc_dec(inc_dec), .ctl_inc_cy(inc_cy), .ctl_inc_oe(inc_oe)
    );

    sm83_adr_sched #(.ADR_WIDTH(16), .LEN_WIDTH(8), .BURST_PRIO(0)) u_dut_cpu_prio (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_gnt(c_gnt),
        .burst_req(burst_req), .burst_base(burst_base), .burst_len(burst_len),
        .burst_lo_only(burst_lo_only), .burst_busy(c_busy), .burst_valid(c_valid),
        .burst_step(burst_step), .burst_done(c_done), .burst_adr(c_adr),
        .ain_sel(c_sel), .ctl_al_hi_we(c_hi), .ctl_al_lo_we(c_lo),
        .ctl_inc_dec(c_dec), .ctl_inc_cy(c_cy), .ctl_inc_oe(c_oe)
    );

    // Address latch/incrementer model: captures on negedge from the scheduler controls.
    always @(negedge clk) begin
        logic [15:0] bus;
        bus = ain_sel ? burst_adr : cpu_bus;
        if (inc_oe) begin
            if (hi_we && lo_we)
                aout <= inc_dec ? aout - {15'd0, inc_cy} : aout + {15'd0, inc_cy};
            else if (lo_we)
                aout[7:0] <= inc_dec ? aout[7:0] - {7'd0, inc_cy} : aout[7:0] + {7'd0, inc_cy};
        end else begin
            if (hi_we) aout[15:8] <= bus[15:8];
            if (lo_we) aout[7:0]  <= bus[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst with burst_step held high; k=1 is the cycle after the accept edge.
    task automatic run_burst(input logic [15:0] base, input logic [7:0] len, input logic lo);
        burst_base = base; burst_len = len; burst_lo_only = lo;
        burst_req = 1'b1; burst_step = 1'b1;
        nv = 0; done_k = 0; ndone = 0; any_we = 1'b0;
        for (int i = 0; i < 4; i++) va[i] = 16'hxxxx;
        cycle();
        burst_req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (burst_valid) begin
                if (nv < 4) va[nv] = aout;
                nv++;
            end
            if (burst_done) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
            if (hi_we || lo_we) any_we = 1'b1;
            if (!burst_busy) break;
            cycle();
        end
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_op = 3'd0; burst_req = 1'b0;
        burst_base = 16'h0; burst_len = 8'h0; burst_lo_only = 1'b0;
        burst_step = 1'b0; cpu_bus = 16'h0;
        repeat (2) cycle();
        check("rst_ctl", ctl, 5'b00000);
        check("rst_gnt", cpu_gnt, 1'b0);
        check("rst_busy", burst_busy, 1'b0);
        check("rst_valid", burst_valid, 1'b0);
        check("rst_done", burst_done, 1'b0);
        check("rst_adr", burst_adr, 16'h0000);
        check("rst_sel", ain_sel, 1'b0);
        reset = 1'b1;
        cycle();

        // CPU op stream: LOAD C000, INC, INC, DEC
        cpu_bus = 16'hC000; cpu_req = 1'b1; cpu_op = 3'd1;
        cycle();
        check("cpu_gnt0", cpu_gnt, 1'b1);
        check("cpu_ctl_load", ctl, 5'b11000);
        cpu_op = 3'd4;
        cycle();
        check("cpu_gnt1", cpu_gnt, 1'b1);
        check("cpu_ctl_inc", ctl, 5'b11011);
        check("cpu_a0", aout, 16'hC000);
        cycle();
        check("cpu_gnt2", cpu_gnt, 1'b1);
        check("cpu_a1", aout, 16'hC001);
        cpu_op = 3'd5;
        cycle();
        check("cpu_gnt3", cpu_gnt, 1'b1);
        check("cpu_ctl_dec", ctl, 5'b11111);
        check("cpu_a2", aout, 16'hC002);
        cpu_req = 1'b0;
        cycle();
        check("cpu_gnt_off", cpu_gnt, 1'b0);
        check("cpu_a3", aout, 16'hC001);
        check("cpu_ctl_idle", ctl, 5'b00000);

        // Plain burst C000 x3
        burst_base = 16'hC000; burst_len = 8'd3; burst_lo_only = 1'b0;
        burst_req = 1'b1; burst_step = 1'b1;
        cycle();
        check("b_load_sel", ain_sel, 1'b1);
        check("b_load_adr", burst_adr, 16'hC000);
        check("b_load_ctl", ctl, 5'b11000);
        check("b_load_busy", burst_busy, 1'b1);
        burst_req = 1'b0;
        repeat (2) cycle();
        check("b_inc_ctl", ctl, 5'b11011);
        check("b_inc_valid", burst_valid, 1'b0);
        repeat (6) cycle();
        check("b_idle_busy", burst_busy, 1'b0);

        run_burst(16'hC000, 8'd3, 1'b0);
        check("b3_nvalid", nv, 3);
        check("b3_a0", va[0], 16'hC000);
        check("b3_a1", va[1], 16'hC001);
        check("b3_a2", va[2], 16'hC002);
        check("b3_done_cycle", done_k, 7);
        check("b3_done_pulses", ndone, 1);

        // Page wrap cases
        run_burst(16'hFEFF, 8'd2, 1'b1);
        check("lo_a0", va[0], 16'hFEFF);
        check("lo_a1", va[1], 16'hFE00);
        run_burst(16'hFEFF, 8'd2, 1'b0);
        check("full_a1", va[1], 16'hFF00);
        run_burst(16'hFFFF, 8'd2, 1'b0);
        check("wrap_a1", va[1], 16'h0000);
        check("wrap_done", ndone, 1);

        // Empty burst
        run_burst(16'h1234, 8'd0, 1'b0);
        check("empty_done_cycle", done_k, 1);
        check("empty_we", any_we, 1'b0);
        check("empty_nvalid", nv, 0);

        // Tie: burst and CPU requested together
        cpu_req = 1'b1; cpu_op = 3'd4;
        burst_base = 16'h2000; burst_len = 8'd1; burst_lo_only = 1'b0;
        burst_req = 1'b1; burst_step = 1'b1;
        cycle();
        check("tie_p1_busy", burst_busy, 1'b1);
        check("tie_p1_gnt", cpu_gnt, 1'b0);
        check("tie_p0_gnt", c_gnt, 1'b1);
        check("tie_p0_busy", c_busy, 1'b0);
        burst_req = 1'b0;
        cycle();
        check("tie_gnt_k2", cpu_gnt, 1'b0);
        cycle();
        check("tie_gnt_k3", cpu_gnt, 1'b0);
        check("tie_done_k3", burst_done, 1'b1);
        cycle();
        check("tie_gnt_k4", cpu_gnt, 1'b0);
        cycle();
        check("tie_gnt_k5", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        cycle();

        // Reset while parked in B_HOLD
        burst_base = 16'h4000; burst_len = 8'd5; burst_req = 1'b1; burst_step = 1'b0;
        cycle();
        burst_req = 1'b0;
        cycle();
        check("mid_valid", burst_valid, 1'b1);
        check("mid_a", aout, 16'h4000);
        reset = 1'b0;
        cycle();
        check("mid_rst_ctl", ctl, 5'b00000);
        check("mid_rst_busy", burst_busy, 1'b0);
        check("mid_rst_done", burst_done, 1'b0);
        check("mid_rst_valid", burst_valid, 1'b0);
        reset = 1'b1; burst_step = 1'b1;
        cycle();
        check("post_rst_busy", burst_busy, 1'b0);
        check("post_rst_done", burst_done, 1'b0);
        check("post_rst_latch", aout, 16'h4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm83_adr_sched.md
Name: sm83_adr_sched

Overview:
Sequencer and arbiter for the SM83 address latch/incrementer. It owns that block's control inputs (hi/lo write enables, inc/dec, carry-in, inc output enable) and its bus-source select. It shares the latch between the CPU microcode requester, which issues one op per cycle, and a burst requester that walks a linear address range, such as an OAM-DMA style copy engine. All control outputs are registered on posedge clk, so they are stable when the incrementer captures on the following negedge.

Parameters:
ADR_WIDTH, 16, address width; must be even.
LEN_WIDTH, 8, width of the burst length.
BURST_PRIO, 1, if 1 burst wins a same-cycle tie in IDLE; if 0 CPU wins.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset.
cpu_req  in  1  CPU op request, held until granted.
cpu_op  in  3  0 HOLD, 1 LOAD, 2 LOAD_LO, 3 LOAD_HI, 4 INC, 5 DEC, 6 INC_LO, 7 DEC_LO.
cpu_gnt  out  1  op sampled at the previous posedge was accepted.
burst_req  in  1  burst request; burst_base and burst_len are sampled on accept.
burst_base  in  ADR_WIDTH  first burst address.
burst_len  in  LEN_WIDTH  number of addresses in the burst; 0 = empty burst.
burst_lo_only  in  1  burst increments touch only the low byte (page wrap).
burst_busy  out  1  burst owns the latch.
burst_valid  out  1  latch holds the current burst address.
burst_step  in  1  consumer done with the current address; sampled only while burst_valid.
burst_done  out  1  one-cycle pulse at burst end.
burst_adr  out  ADR_WIDTH  value driven onto the latch bus input during burst load.
ain_sel  out  1  0 = CPU bus source, 1 = burst_adr.
ctl_al_hi_we, ctl_al_lo_we, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe  out  1 each  incrementer controls.

Behaviour:
- States: IDLE, CPU, B_LOAD, B_HOLD, B_INC, B_END.
- Reset (reset=0 at posedge):
  - State goes to IDLE; all outputs 0; burst_adr = 0; remaining count = 0.
  - Applies mid-burst too: burst_done is not pulsed and the burst is dropped.
- Op encoding, per ctl outputs for one cycle:
  - HOLD: all 0.
  - LOAD: hi_we = lo_we = 1, oe = 0.
  - LOAD_LO / LOAD_HI: only the matching we = 1.
  - INC: hi_we = lo_we = oe = cy = 1, dec = 0.
  - DEC: as INC with dec = 1.
  - INC_LO / DEC_LO: lo_we = oe = cy = 1, hi_we = 0, dec = 0 / 1 respectively.
- Arbitration at each posedge while in IDLE or CPU:
  - If burst_req and (BURST_PRIO or !cpu_req): latch burst_base and burst_len, burst_busy = 1.
    - burst_len = 0 → B_END.
    - otherwise → B_LOAD.
  - Else if cpu_req: register the cpu_op controls, cpu_gnt = 1, state CPU.
  - Else: all ctl = 0, cpu_gnt = 0, state IDLE.
  - Back-to-back CPU ops are accepted every cycle while cpu_req stays high.
- B_LOAD (1 cycle): ain_sel = 1, burst_adr = base, LOAD op issued → B_HOLD.
- B_HOLD:
  - ctl all 0, burst_valid = 1.
  - On burst_step: remaining == 1 → B_END; else → B_INC with remaining − 1.
- B_INC (1 cycle):
  - burst_valid = 0.
  - Issues INC, or INC_LO if burst_lo_only was latched at accept.
  - → B_HOLD.
- B_END (1 cycle): burst_done = 1, burst_busy = 0, ctl all 0 → IDLE.
- cpu_gnt is 0 in every burst state; pending CPU requests wait.
- Latency: an op issued in cycle N updates the latch at negedge N; the new address is valid from cycle N+1. Burst throughput is one address per 2 cycles.
- Wrap-around:
  - Full-width increment wraps FFFF→0000 with no special handling.
  - lo_only wraps xxFF→xx00 and the high byte is unchanged.
- burst_len = 2^LEN_WIDTH is not representable; the maximum burst is 2^LEN_WIDTH − 1 addresses.
- burst_step outside B_HOLD is ignored. burst_req held during a burst is not re-accepted until IDLE.

Test Plan:
- Reset: drive reset=0 mid-burst in B_HOLD → next cycle all ctl 0, busy 0, done 0, state IDLE; latch keeps its value.
- CPU sequence: cpu_req=1 with ops LOAD (bus C000), INC, INC, DEC over 4 cycles → cpu_gnt high 4 cycles; aout = C000, C001, C002, C001.
- Burst: base C000, len 3, step whenever valid → LOAD, then valid at C000, C001, C002; 7 cycles from accept to done; single done pulse.
- Page wrap: base FEFF, len 2, lo_only=1 → second address FE00. Same with lo_only=0 → FF00. Base FFFF, lo_only=0 → 0000.
- Tie and stall: burst_req and cpu_req together with BURST_PRIO=1 → burst first, cpu_gnt=0 until done, CPU op granted the cycle after IDLE. With BURST_PRIO=0 → CPU first.
- Empty burst: len 0 → busy for 1 cycle, done pulse, no we asserted.
